// File: rtl/dcache_dataram_ctrl_pkg.sv
// Shared D-cache line types and constants for the data-array controller.
package dcache_dataram_ctrl_pkg;

  localparam int DCACHE_LINE_BYTES = 32;
  localparam int DCACHE_DATA_W     = DCACHE_LINE_BYTES * 8;
  localparam int DCACHE_DIRTY_BIT  = 256;
  localparam int DCACHE_LINE_W     = DCACHE_DATA_W + 1;

  typedef logic [DCACHE_LINE_W-1:0] DCacheLine;

endpackage

// File: rtl/dcache_line_merge.sv
// Byte-masked merge of store data into an existing line; the result is always marked dirty.
module dcache_line_merge
  import dcache_dataram_ctrl_pkg::*;
(
  input  DCacheLine                    old_line_i,
  input  logic [DCACHE_DATA_W-1:0]     st_dat_i,
  input  logic [DCACHE_LINE_BYTES-1:0] st_sel_i,
  output DCacheLine                    merged_o
);

  // Per-byte select between store data and the line read from the array
  always_comb begin
    merged_o = old_line_i;
    for (int b = 0; b < DCACHE_LINE_BYTES; b++) begin
      merged_o[b*8 +: 8] = st_sel_i[b] ? st_dat_i[b*8 +: 8] : old_line_i[b*8 +: 8];
    end
    merged_o[DCACHE_DIRTY_BIT] = 1'b1;
  end

endmodule

// File: rtl/dcache_dataram_ctrl.sv
// D-cache data-array sequencer: fill/store-RMW/load arbitration with write-to-read forwarding.
// Optional performance counters are enabled by defining DCACHE_CTRL_PERF_EN.
module dcache_dataram_ctrl
  import dcache_dataram_ctrl_pkg::*;
#(
  parameter int AWID          = 10,
  parameter int STORE_AGE_MAX = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fill_req,
  input  logic [AWID-1:0]              fill_adr,
  input  DCacheLine                    fill_dat,
  output logic                         fill_ack,
  input  logic                         st_req,
  input  logic [AWID-1:0]              st_adr,
  input  logic [DCACHE_LINE_BYTES-1:0] st_sel,
  input  logic [DCACHE_DATA_W-1:0]     st_dat,
  output logic                         st_ack,
  input  logic                         ld_req,
  input  logic [AWID-1:0]              ld_adr,
  output logic                         ld_ack,
  output logic                         ld_valid,
  output DCacheLine                    ld_dat,
  output logic                         ram_wr,
  output logic [AWID-1:0]              ram_wadr,
  output logic [AWID-1:0]              ram_radr,
  output DCacheLine                    ram_i,
  input  DCacheLine                    ram_o
`ifdef DCACHE_CTRL_PERF_EN
  ,
  output logic [31:0]                  perf_st_stall,
  output logic [31:0]                  perf_fwd,
  output logic [31:0]                  perf_fill
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ST_RD = 2'd1,
    ST_WR = 2'd2
  } state_e;

  localparam int AGE_W = (STORE_AGE_MAX < 1) ? 1 : $clog2(STORE_AGE_MAX + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STORE_AGE_MAX);

  state_e           state_q, state_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             ld_valid_q, fwd_q;
  DCacheLine        fwd_dat_q, ld_hold_q;
  DCacheLine        merged_s;
  logic             st_start_s, ld_lost_s, fwd_hit_s;

  dcache_line_merge u_merge (
    .old_line_i (ram_o),
    .st_dat_i   (st_dat),
    .st_sel_i   (st_sel),
    .merged_o   (merged_s)
  );

  // A starving store takes the read port once it has lost it STORE_AGE_MAX times
  assign st_start_s = rst && (state_q == IDLE) && !fill_req && st_req
                      && (!ld_req || (age_q == AGE_MAX));
  assign ld_lost_s  = (state_q == IDLE) && !fill_req && st_req && ld_req
                      && (age_q != AGE_MAX);

  // State and age registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
    end
  end

  // Next-state and age update
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = st_start_s ? ST_RD : IDLE;
      ST_RD:   state_d = ST_WR;
      ST_WR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (st_ack) begin
      age_d = '0;
    end else if (ld_lost_s) begin
      age_d = age_q + AGE_W'(1);
    end else begin
      age_d = age_q;
    end
  end

  // Array port and handshake outputs; everything is held quiet while reset is asserted
  always_comb begin
    fill_ack = 1'b0;
    st_ack   = 1'b0;
    ld_ack   = 1'b0;
    ram_wr   = 1'b0;
    ram_wadr = '0;
    ram_radr = '0;
    ram_i    = '0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (fill_req) begin
            ram_wr   = 1'b1;
            ram_wadr = fill_adr;
            ram_i    = fill_dat;
            fill_ack = 1'b1;
          end else begin
            ram_wr   = 1'b0;
          end
          ld_ack   = ld_req && !st_start_s;
          ram_radr = ld_ack ? ld_adr : '0;
        end
        ST_RD: begin
          ram_radr = st_adr;
        end
        ST_WR: begin
          ram_wr   = 1'b1;
          ram_wadr = st_adr;
          ram_i    = merged_s;
          st_ack   = 1'b1;
          ld_ack   = ld_req;
          ram_radr = ld_req ? ld_adr : '0;
        end
        default: begin
          ram_wr = 1'b0;
        end
      endcase
    end else begin
      ram_wr = 1'b0;
    end
  end

  assign fwd_hit_s = ld_ack && ram_wr && (ram_wadr == ld_adr);

  // Load return pipeline: forwarded write data and last-value hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_valid_q <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_dat_q  <= '0;
      ld_hold_q  <= '0;
    end else begin
      ld_valid_q <= ld_ack;
      fwd_q      <= fwd_hit_s;
      if (fwd_hit_s) begin
        fwd_dat_q <= ram_i;
      end
      if (ld_valid_q) begin
        ld_hold_q <= ld_dat;
      end
    end
  end

  assign ld_valid = ld_valid_q;
  assign ld_dat   = !ld_valid_q ? ld_hold_q : (fwd_q ? fwd_dat_q : ram_o);

`ifdef DCACHE_CTRL_PERF_EN
  logic [31:0] perf_st_stall_q, perf_fwd_q, perf_fill_q;

  // Free-running event counters, wrapping modulo 2^32
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_st_stall_q <= 32'd0;
      perf_fwd_q      <= 32'd0;
      perf_fill_q     <= 32'd0;
    end else begin
      if ((state_q == IDLE) && st_req && !st_start_s) begin
        perf_st_stall_q <= perf_st_stall_q + 32'd1;
      end
      if (ld_valid_q && fwd_q) begin
        perf_fwd_q <= perf_fwd_q + 32'd1;
      end
      if (fill_ack) begin
        perf_fill_q <= perf_fill_q + 32'd1;
      end
    end
  end

  assign perf_st_stall = perf_st_stall_q;
  assign perf_fwd      = perf_fwd_q;
  assign perf_fill     = perf_fill_q;
`endif

endmodule
